// File: rtl/conv_out_writeback.sv
// conv_out_writeback
// Output stage of a convolution layer. It takes one finished accumulator sum per output pixel
// per output channel, then:
//   - adds the per-channel bias,
//   - rounds away the fractional bits,
//   - applies optional ReLU and saturates to DATA_WIDTH,
//   - writes the word into the output feature RAM at a generated address.
// It raises layer_done once the last word of the layer has been written.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       level from control; its rising edge arms a new layer (and aborts a running one)
//   mac_valid   one-cycle strobe: mac_result holds a complete sum
//   mac_result  signed accumulator sum (ACC_WIDTH)
//   bias_all    per-channel signed bias in output Q format, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_wren    output RAM write enable
//   out_addr    output RAM write address (ch*W*H + y*W + x)
//   out_data    output RAM write data
//   layer_done  high once all results of the layer are written; held until the next start edge
//   sat_flag    sticky: some result of the current layer saturated
//   seq_err     sticky: mac_valid arrived while idle or done
//
// Pipeline: strobe in cycle t -> S1 (bias add) -> S2 (round) -> S3 (clamp, output regs).
// out_wren is therefore high in cycle t+3. There is no back-pressure.

module conv_out_writeback #(
   parameter int unsigned DATA_WIDTH          = 16,
   parameter int unsigned ACC_WIDTH           = 40,
   parameter int unsigned FRAC_SHIFT          = 8,
   parameter int unsigned NUM_ONEMULT         = 2,
   parameter int unsigned OUT_FEATURE_WIDTH_W = 4,
   parameter int unsigned OUT_FEATURE_WIDTH_H = 4,
   parameter int unsigned ADDR_WIDTH          = 10,
   parameter int unsigned RELU_EN             = 1,
   parameter int unsigned SKIP_FIRST          = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              mac_valid,
   input  logic signed [ACC_WIDTH-1:0]       mac_result,
   input  logic [DATA_WIDTH*NUM_ONEMULT-1:0] bias_all,
   output logic                              out_wren,
   output logic [ADDR_WIDTH-1:0]             out_addr,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              layer_done,
   output logic                              sat_flag,
   output logic                              seq_err
);

   localparam int unsigned SUM_W  = ACC_WIDTH + 1;
   // One extra bit so that adding the rounding constant can never wrap.
   localparam int unsigned RND_W  = ACC_WIDTH + 2;
   localparam int unsigned CH_W   = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;
   localparam int unsigned X_W    = (OUT_FEATURE_WIDTH_W > 1) ? $clog2(OUT_FEATURE_WIDTH_W) : 1;
   localparam int unsigned Y_W    = (OUT_FEATURE_WIDTH_H > 1) ? $clog2(OUT_FEATURE_WIDTH_H) : 1;
   localparam int unsigned SKIP_W = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;
   localparam int unsigned PLANE  = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H;

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_ONEMULT - 1);
   localparam logic [X_W-1:0]  X_LAST  = X_W'(OUT_FEATURE_WIDTH_W - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(OUT_FEATURE_WIDTH_H - 1);

   localparam logic [RND_W-1:0] HALF = RND_W'(1) << (FRAC_SHIFT - 1);
   localparam logic signed [RND_W-1:0] MAX_V =
      {{(RND_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [RND_W-1:0] MIN_V =
      {{(RND_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e state_q, state_d;

   logic                   start_q;
   logic                   start_edge;
   logic [CH_W-1:0]        ch_q, ch_d, ch_eff;
   logic [X_W-1:0]         x_q, x_d, x_eff;
   logic [Y_W-1:0]         y_q, y_d, y_eff;
   logic [SKIP_W-1:0]      skip_q, skip_d, skip_eff;
   logic                   active, take, skip_hit, last_take, seq_hit, done_set;

   logic                   v1_q, v2_q;
   logic [DATA_WIDTH-1:0]  bias_sel;
   logic signed [SUM_W-1:0] bias_ext, acc_ext, sum_d, sum_q;
   logic [ADDR_WIDTH-1:0]  addr_d, addr1_q, addr2_q;
   logic signed [RND_W-1:0] rnd_sum, r_d, r_q;
   logic [DATA_WIDTH-1:0]  data_s3;
   logic                   sat_s3;

   assign start_edge = start & ~start_q;

   // ---------------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. A start edge from any state begins a new layer. The sample arriving in
   // the same cycle already belongs to that new layer.
   always_comb begin
      state_d = state_q;
      if (start_edge) begin
         state_d = last_take ? StFlush : StRun;
      end else begin
         case (state_q)
            StRun:   if (last_take) state_d = StFlush;
            StFlush: if (!v1_q && !v2_q) state_d = StDone;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM: outputs (per-cycle control strobes)
   always_comb begin
      active   = start_edge || (state_q == StRun);
      seq_hit  = mac_valid && !start_edge && ((state_q == StIdle) || (state_q == StDone));
      // In FLUSH the last word sits in the output register once S1/S2 are empty.
      done_set = !start_edge && (state_q == StFlush) && !v1_q && !v2_q;
   end

   // ---------------------------------------------------------------------------------------------
   // Sample counters and skip handling
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      ch_eff   = start_edge ? '0 : ch_q;
      x_eff    = start_edge ? '0 : x_q;
      y_eff    = start_edge ? '0 : y_q;
      skip_eff = start_edge ? SKIP_W'(SKIP_FIRST) : skip_q;

      take      = mac_valid && active && (skip_eff == '0);
      skip_hit  = mac_valid && active && (skip_eff != '0);
      last_take = take && (ch_eff == CH_LAST) && (x_eff == X_LAST) && (y_eff == Y_LAST);

      ch_d   = ch_eff;
      x_d    = x_eff;
      y_d    = y_eff;
      skip_d = skip_hit ? (skip_eff - SKIP_W'(1)) : skip_eff;
      if (take) begin
         if (ch_eff == CH_LAST) begin
            ch_d = '0;
            if (x_eff == X_LAST) begin
               x_d = '0;
               y_d = (y_eff == Y_LAST) ? '0 : (y_eff + Y_W'(1));
            end else begin
               x_d = x_eff + X_W'(1);
            end
         end else begin
            ch_d = ch_eff + CH_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------------------------
   // S1: bias add. Bias is in output Q format, so align it to the accumulator's binary point.
   always_comb begin
      bias_sel = bias_all[DATA_WIDTH-1:0];
      for (int unsigned c = 0; c < NUM_ONEMULT; c++) begin
         if (ch_eff == CH_W'(c)) bias_sel = bias_all[c*DATA_WIDTH +: DATA_WIDTH];
      end
      bias_ext = {{(SUM_W - DATA_WIDTH){bias_sel[DATA_WIDTH-1]}}, bias_sel} <<< FRAC_SHIFT;
      acc_ext  = {mac_result[ACC_WIDTH-1], mac_result};
      sum_d    = acc_ext + bias_ext;
      addr_d   = ADDR_WIDTH'(32'(ch_eff) * PLANE + 32'(y_eff) * OUT_FEATURE_WIDTH_W
                             + 32'(x_eff));
   end

   // S2: round half up, then arithmetic shift.
   always_comb begin
      rnd_sum = {sum_q[SUM_W-1], sum_q} + HALF;
      r_d     = rnd_sum >>> FRAC_SHIFT;
   end

   // S3: ReLU takes precedence, so a clamped negative never counts as saturation.
   always_comb begin
      data_s3 = r_q[DATA_WIDTH-1:0];
      sat_s3  = 1'b0;
      if ((RELU_EN != 0) && r_q[RND_W-1]) begin
         data_s3 = '0;
      end else if (r_q > MAX_V) begin
         data_s3 = DATA_MAX;
         sat_s3  = 1'b1;
      end else if (r_q < MIN_V) begin
         data_s3 = DATA_MIN;
         sat_s3  = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Registers. A start edge flushes S2/S3 in the same cycle, so the old layer writes nothing
   // further. S1 is reloaded with whatever the new layer accepts.
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         start_q    <= 1'b0;
         ch_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         skip_q     <= '0;
         v1_q       <= 1'b0;
         sum_q      <= '0;
         addr1_q    <= '0;
         v2_q       <= 1'b0;
         r_q        <= '0;
         addr2_q    <= '0;
         out_wren   <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         layer_done <= 1'b0;
         sat_flag   <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         start_q <= start;
         ch_q    <= ch_d;
         x_q     <= x_d;
         y_q     <= y_d;
         skip_q  <= skip_d;

         v1_q <= take;
         if (take) begin
            sum_q   <= sum_d;
            addr1_q <= addr_d;
         end

         v2_q <= v1_q && !start_edge;
         if (v1_q) begin
            r_q     <= r_d;
            addr2_q <= addr1_q;
         end

         out_wren <= v2_q && !start_edge;
         if (v2_q && !start_edge) begin
            out_data <= data_s3;
            out_addr <= addr2_q;
         end

         layer_done <= !start_edge && (layer_done || done_set);
         sat_flag   <= !start_edge && (sat_flag || (v2_q && sat_s3));
         seq_err    <= !start_edge && (seq_err || seq_hit);
      end
   end

endmodule

// File: tb/tb_conv_out_writeback.sv
// Bench for conv_out_writeback with W=H=2, NUM_ONEMULT=2, SKIP_FIRST=1.
// Two instances share the stimulus: one with ReLU on and one with ReLU off.
// Each issued sample pushes its hand-computed {addr, data, write cycle} into a per-instance queue.
// Monitors pop the queue on every out_wren and compare.
module tb_conv_out_writeback;
   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 40;
   localparam int unsigned NM  = 2;
   localparam int unsigned ADW = 10;

   typedef struct packed {
      logic [ADW-1:0] addr;
      logic [DW-1:0]  data;
      logic [31:0]    cyc;
   } exp_t;

   logic                 clock      = 1'b0;
   logic                 reset      = 1'b1;
   logic                 start      = 1'b0;
   logic                 mac_valid  = 1'b0;
   logic signed [AW-1:0] mac_result = '0;
   logic [DW*NM-1:0]     bias_all   = '0;

   logic           wren_r, done_r, sat_r, err_r;
   logic [ADW-1:0] addr_r;
   logic [DW-1:0]  data_r;
   logic           wren_n, done_n, sat_n, err_n;
   logic [ADW-1:0] addr_n;
   logic [DW-1:0]  data_n;

   exp_t        q_r[$];
   exp_t        q_n[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] cyc   = '0;

   // Address order for ch fastest, then x, then y, on a 2x2 map with 2 channels.
   logic [ADW-1:0] addr_tab [8] = '{10'd0, 10'd4, 10'd1, 10'd5, 10'd2, 10'd6, 10'd3, 10'd7};

   // Negative-range layer: sums with expected ReLU / no-ReLU results.
   logic signed [AW-1:0] l3_mac [8] = '{-40'sh7FFFFF00, -40'sh800000, 40'sh7FFF00, 40'sh80,
                                        -40'sh80, -40'sh81, 40'sh7F, 40'sh100};
   logic [DW-1:0] l3_r [8] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0001,
                               16'h0000, 16'h0000, 16'h0000, 16'h0001};
   logic [DW-1:0] l3_n [8] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0001,
                               16'h0000, 16'hFFFF, 16'h0000, 16'h0001};

   conv_out_writeback #(
      .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_SHIFT(8), .NUM_ONEMULT(NM),
      .OUT_FEATURE_WIDTH_W(2), .OUT_FEATURE_WIDTH_H(2), .ADDR_WIDTH(ADW),
      .RELU_EN(1), .SKIP_FIRST(1)
   ) dut_r (
      .clock(clock), .reset(reset), .start(start), .mac_valid(mac_valid),
      .mac_result(mac_result), .bias_all(bias_all), .out_wren(wren_r), .out_addr(addr_r),
      .out_data(data_r), .layer_done(done_r), .sat_flag(sat_r), .seq_err(err_r)
   );

   conv_out_writeback #(
      .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_SHIFT(8), .NUM_ONEMULT(NM),
      .OUT_FEATURE_WIDTH_W(2), .OUT_FEATURE_WIDTH_H(2), .ADDR_WIDTH(ADW),
      .RELU_EN(0), .SKIP_FIRST(1)
   ) dut_n (
      .clock(clock), .reset(reset), .start(start), .mac_valid(mac_valid),
      .mac_result(mac_result), .bias_all(bias_all), .out_wren(wren_n), .out_addr(addr_n),
      .out_data(data_n), .layer_done(done_n), .sat_flag(sat_n), .seq_err(err_n)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitors: {addr, data, cycle} of every write must match the head of the queue.
   always @(negedge clock) begin
      exp_t e;
      if (wren_r === 1'b1) begin
         if (q_r.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stray_write_relu: actual addr=%0h data=%0h, required no write",
                     addr_r, data_r);
         end else begin
            e = q_r.pop_front();
            check("write_relu", {6'd0, addr_r, data_r, cyc}, {6'd0, e.addr, e.data, e.cyc});
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (wren_n === 1'b1) begin
         if (q_n.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stray_write_norelu: actual addr=%0h data=%0h, required no write",
                     addr_n, data_n);
         end else begin
            e = q_n.pop_front();
            check("write_norelu", {6'd0, addr_n, data_n, cyc}, {6'd0, e.addr, e.data, e.cyc});
         end
      end
   end

   // One strobe. When push is set, the write is expected 3 cycles after the strobe cycle.
   task automatic mac(input logic signed [AW-1:0] v, input logic [DW-1:0] er,
                      input logic [DW-1:0] en, input int idx, input bit push);
      mac_valid  = 1'b1;
      mac_result = v;
      if (push) begin
         q_r.push_back('{addr: addr_tab[idx], data: er, cyc: cyc + 32'd3});
         q_n.push_back('{addr: addr_tab[idx], data: en, cyc: cyc + 32'd3});
      end
      @(posedge clock);
      #1;
      mac_valid = 1'b0;
   endtask

   task automatic start_edge();
      start = 1'b0;
      @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   // {layer_done, sat_flag, seq_err} for both instances.
   task automatic status(input string tag, input logic [2:0] req_r, input logic [2:0] req_n);
      check({tag, "_relu"}, {61'd0, done_r, sat_r, err_r}, {61'd0, req_r});
      check({tag, "_norelu"}, {61'd0, done_n, sat_n, err_n}, {61'd0, req_n});
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_relu"}, {34'd0, wren_r, addr_r, data_r, done_r, sat_r, err_r}, 64'd0);
      check({tag, "_norelu"}, {34'd0, wren_n, addr_n, data_n, done_n, sat_n, err_n}, 64'd0);
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      all_zero("reset_state");
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Basic layer: first strobe dropped, then k<<8 -> k.
      start_edge();
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      for (int k = 1; k <= 8; k++) mac(40'(k * 256), DW'(k), DW'(k), k - 1, 1'b1);
      wait_neg(2);
      status("done_at_last_write", 3'b000, 3'b000);
      wait_neg(1);
      status("done_after_last_write", 3'b100, 3'b100);

      // Bias and rounding: ch0 bias 5, ch1 bias -3.
      bias_all = {16'hFFFD, 16'h0005};
      start_edge();
      status("clear_on_start", 3'b000, 3'b000);
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) mac(40'sh180, 16'h0007, 16'h0007, i, 1'b1);
         else            mac(40'sh17F, 16'h0000, 16'hFFFE, i, 1'b1);
      end
      wait_neg(3);
      status("bias_layer", 3'b100, 3'b100);

      // Negative range: ReLU clamps without flagging; no-ReLU saturates to 0x8000.
      bias_all = '0;
      start_edge();
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      for (int i = 0; i < 8; i++) mac(l3_mac[i], l3_r[i], l3_n[i], i, 1'b1);
      wait_neg(3);
      status("neg_layer", 3'b100, 3'b110);

      // Positive saturation, then abort after 3 writes.
      start_edge();
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      mac(40'sh7FFFFF00, 16'h7FFF, 16'h7FFF, 0, 1'b1);
      mac(40'sh100, 16'h0001, 16'h0001, 1, 1'b1);
      mac(40'sh200, 16'h0002, 16'h0002, 2, 1'b1);
      mac(40'sh300, 16'd0, 16'd0, 0, 1'b0);
      start = 1'b0;
      mac(40'sh400, 16'd0, 16'd0, 0, 1'b0);
      status("pre_abort", 3'b010, 3'b010);
      start = 1'b1;
      @(posedge clock);
      #1;
      status("post_abort", 3'b000, 3'b000);
      // New layer after abort: addresses restart at 0 after one skipped strobe.
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      for (int k = 1; k <= 8; k++) mac(40'((k + 8) * 256), DW'(k + 8), DW'(k + 8), k - 1, 1'b1);
      wait_neg(3);
      status("after_abort_layer", 3'b100, 3'b100);

      // Strobes in DONE: no write, seq_err set, layer_done held.
      mac(40'sh500, 16'd0, 16'd0, 0, 1'b0);
      mac(40'sh600, 16'd0, 16'd0, 0, 1'b0);
      wait_neg(3);
      status("seq_err", 3'b101, 3'b101);

      // Reset with two samples in flight.
      start_edge();
      mac(40'sd0, 16'd0, 16'd0, 0, 1'b0);
      mac(40'sh100, 16'd0, 16'd0, 0, 1'b0);
      mac(40'sh200, 16'd0, 16'd0, 0, 1'b0);
      reset = 1'b0;
      start = 1'b0;
      #1;
      all_zero("reset_in_flight");
      @(posedge clock);
      #1;
      reset = 1'b1;
      wait_neg(6);
      all_zero("after_reset_release");

      check("queue_relu_drained", 64'(q_r.size()), 64'd0);
      check("queue_norelu_drained", 64'(q_n.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
